// File: rtl/exec_ctrl_mem_unit_pkg.sv
// Shared definitions for the execute/memory slice of the 12-bit RISC-V-subset
// datapath: data widths, opcode/funct encodings, ALU control encodings and the
// packed control bundle passed from the decoder to the datapath.
package exec_ctrl_mem_unit_pkg;

  localparam int unsigned DW        = 12;
  localparam int unsigned MEM_WORDS = 32;
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam int unsigned IMM_W     = 12;

  typedef enum logic [6:0] {
    OP_RTYPE  = 7'b0110011,
    OP_ITYPE  = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      mem_to_reg;
    logic      alu_src;
    logic      branch;
    alu_op_e   alu_op;
    alu_ctrl_e alu_ctrl;
  } ctrl_t;

  // Decode result for anything not in the supported subset.
  localparam ctrl_t CTRL_NOP = '{
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    alu_src:    1'b0,
    branch:     1'b0,
    alu_op:     ALUOP_MEM,
    alu_ctrl:   ALU_ADD
  };

  function automatic logic [DW-1:0] alu_compute(input alu_ctrl_e op,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (op)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SUB: r = a - b;
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exec_ctrl_decoder.sv
// Combinational instruction decoder.
//   instr_i : 32-bit instruction
//   ctrl_o  : control bundle (write/read enables, ALUSrc, Branch, ALUOp, ALUcontrol)
//   imm_o   : 12-bit signed immediate (I, S or B format; 0 for R-type/unknown)
module exec_ctrl_decoder
  import exec_ctrl_mem_unit_pkg::*;
(
  input  logic [31:0]      instr_i,
  output ctrl_t            ctrl_o,
  output logic [IMM_W-1:0] imm_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  ctrl_t            ctrl_c;
  logic [IMM_W-1:0] imm_c;
  logic             valid_c;

  always_comb begin
    ctrl_c  = CTRL_NOP;
    imm_c   = '0;
    valid_c = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_op    = ALUOP_RTYPE;
        if (funct3 == F3_ADD_SUB && funct7 == F7_ADD) begin
          ctrl_c.alu_ctrl = ALU_ADD;
          valid_c         = 1'b1;
        end else if (funct3 == F3_ADD_SUB && funct7 == F7_SUB) begin
          ctrl_c.alu_ctrl = ALU_SUB;
          valid_c         = 1'b1;
        end else if (funct3 == F3_AND) begin
          ctrl_c.alu_ctrl = ALU_AND;
          valid_c         = 1'b1;
        end else if (funct3 == F3_OR) begin
          ctrl_c.alu_ctrl = ALU_OR;
          valid_c         = 1'b1;
        end
      end
      OP_ITYPE: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_op    = ALUOP_ITYPE;
        imm_c            = instr_i[31:20];
        valid_c          = 1'b1;
        case (funct3)
          F3_ADD_SUB: ctrl_c.alu_ctrl = ALU_ADD;
          F3_AND:     ctrl_c.alu_ctrl = ALU_AND;
          F3_OR:      ctrl_c.alu_ctrl = ALU_OR;
          default:    valid_c         = 1'b0;
        endcase
      end
      OP_LOAD: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_read   = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.alu_src    = 1'b1;
        imm_c             = instr_i[31:20];
        valid_c           = (funct3 == F3_WORD);
      end
      OP_STORE: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        imm_c            = {instr_i[31:25], instr_i[11:7]};
        valid_c          = (funct3 == F3_WORD);
      end
      OP_BRANCH: begin
        ctrl_c.branch   = 1'b1;
        ctrl_c.alu_op   = ALUOP_BRANCH;
        ctrl_c.alu_ctrl = ALU_SUB;
        // offset[12:1]; the branch adder restores the implicit zero LSB.
        imm_c           = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]};
        valid_c         = (funct3 == F3_BEQ);
      end
      default: ;
    endcase
  end

  // Unsupported encodings collapse to a harmless ADD with no side effects.
  assign ctrl_o = valid_c ? ctrl_c : CTRL_NOP;
  assign imm_o  = valid_c ? imm_c : '0;

endmodule

// File: rtl/exec_ctrl_mem_unit.sv
// Execute/memory slice of the 12-bit single-cycle RISC-V-subset datapath.
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   instrucao, linha    : current instruction and PC (byte address)
//   data1, data2        : rs1 / rs2 values from the register file
//   mem_init            : reset image of the 32 x 12-bit data memory
//   RegWrite..Branch, ALUOp, ALUcontrol, ImmGen : decoded controls
//   ALUresult, zero     : ALU output and its zero flag
//   sum, line           : branch target and branch-taken flag
//   Writedata           : register write-back value
//   Memoria_saida       : full memory contents, packed like mem_init
module exec_ctrl_mem_unit
  import exec_ctrl_mem_unit_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             instrucao,
  input  logic [DW-1:0]           linha,
  input  logic [DW-1:0]           data1,
  input  logic [DW-1:0]           data2,
  input  logic [MEM_WORDS*DW-1:0] mem_init,
  output logic                    RegWrite,
  output logic                    MemRead,
  output logic                    MemWrite,
  output logic                    MemtoReg,
  output logic                    ALUSrc,
  output logic                    Branch,
  output logic [1:0]              ALUOp,
  output logic [3:0]              ALUcontrol,
  output logic [DW-1:0]           ImmGen,
  output logic [DW-1:0]           ALUresult,
  output logic                    zero,
  output logic [DW-1:0]           sum,
  output logic                    line,
  output logic [DW-1:0]           Writedata,
  output logic [MEM_WORDS*DW-1:0] Memoria_saida
);

  ctrl_t            ctrl;
  logic [DW-1:0]    imm;
  logic [DW-1:0]    alu_b;
  logic [DW-1:0]    alu_res;
  logic [IDX_W-1:0] mem_idx;

  logic [MEM_WORDS-1:0][DW-1:0] mem_q;
  logic [MEM_WORDS-1:0][DW-1:0] mem_view;

  exec_ctrl_decoder u_decoder (
    .instr_i (instrucao),
    .ctrl_o  (ctrl),
    .imm_o   (imm)
  );

  assign alu_b   = ctrl.alu_src ? imm : data2;
  assign alu_res = alu_compute(ctrl.alu_ctrl, data1, alu_b);

  // Upper address bits are ignored, so addresses alias modulo the memory size.
  assign mem_idx = alu_res[IDX_W+1:2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q <= mem_init;
    end else if (ctrl.mem_write) begin
      mem_q[mem_idx] <= data2;
    end
  end

  // While reset is held the image tracks mem_init live, not just its value
  // at the falling edge of reset.
  assign mem_view = reset ? mem_q : mem_init;

  assign RegWrite   = ctrl.reg_write;
  assign MemRead    = ctrl.mem_read;
  assign MemWrite   = ctrl.mem_write;
  assign MemtoReg   = ctrl.mem_to_reg;
  assign ALUSrc     = ctrl.alu_src;
  assign Branch     = ctrl.branch;
  assign ALUOp      = ctrl.alu_op;
  assign ALUcontrol = ctrl.alu_ctrl;
  assign ImmGen     = imm;

  assign ALUresult = alu_res;
  assign zero      = (alu_res == '0);
  assign sum       = linha + {imm[DW-2:0], 1'b0};
  assign line      = ctrl.branch & zero;

  assign Writedata     = ctrl.mem_to_reg ? mem_view[mem_idx] : alu_res;
  assign Memoria_saida = mem_view;

endmodule

// File: tb/tb_exec_ctrl_mem_unit.sv
module tb_exec_ctrl_mem_unit;

  logic         clock;
  logic         reset;
  logic [31:0]  instrucao;
  logic [11:0]  linha, data1, data2;
  logic [383:0] mem_init;
  logic         RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch;
  logic [1:0]   ALUOp;
  logic [3:0]   ALUcontrol;
  logic [11:0]  ImmGen, ALUresult, sum, Writedata;
  logic         zero, line;
  logic [383:0] Memoria_saida;

  int tests  = 0;
  int failed = 0;

  exec_ctrl_mem_unit dut (
    .clock         (clock),
    .reset         (reset),
    .instrucao     (instrucao),
    .linha         (linha),
    .data1         (data1),
    .data2         (data2),
    .mem_init      (mem_init),
    .RegWrite      (RegWrite),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .MemtoReg      (MemtoReg),
    .ALUSrc        (ALUSrc),
    .Branch        (Branch),
    .ALUOp         (ALUOp),
    .ALUcontrol    (ALUcontrol),
    .ImmGen        (ImmGen),
    .ALUresult     (ALUresult),
    .zero          (zero),
    .sum           (sum),
    .line          (line),
    .Writedata     (Writedata),
    .Memoria_saida (Memoria_saida)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [11:0] pc, d1, d2;
    logic [5:0]  ctl;     // {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch}
    logic [1:0]  aluop;
    logic [3:0]  aluctl;
    logic [11:0] imm, res;
    logic        z;
    logic [11:0] tgt;
    logic        tkn;
    logic [11:0] wd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] word(input int unsigned i);
    return Memoria_saida[i*12 +: 12];
  endfunction

  function automatic vec_t mk(input string n, input logic [31:0] i, input logic [11:0] pc,
                              input logic [11:0] a, input logic [11:0] b, input logic [5:0] c,
                              input logic [1:0] op, input logic [3:0] ac, input logic [11:0] im,
                              input logic [11:0] r, input logic z, input logic [11:0] t,
                              input logic k, input logic [11:0] w);
    vec_t v;
    v.name = n; v.instr = i; v.pc = pc; v.d1 = a; v.d2 = b; v.ctl = c;
    v.aluop = op; v.aluctl = ac; v.imm = im; v.res = r; v.z = z;
    v.tgt = t; v.tkn = k; v.wd = w;
    return v;
  endfunction

  initial begin
    vecs[0] = mk("add",    32'h002081B3, 12'h000, 12'h005, 12'h007, 6'b100000, 2'b10, 4'b0010, 12'h000, 12'h00C, 1'b0, 12'h000, 1'b0, 12'h00C);
    vecs[1] = mk("sub",    32'h402081B3, 12'h000, 12'h005, 12'h007, 6'b100000, 2'b10, 4'b0110, 12'h000, 12'hFFE, 1'b0, 12'h000, 1'b0, 12'hFFE);
    vecs[2] = mk("addi",   32'hFFF00093, 12'h000, 12'h000, 12'h000, 6'b100010, 2'b11, 4'b0010, 12'hFFF, 12'hFFF, 1'b0, 12'hFFE, 1'b0, 12'hFFF);
    vecs[3] = mk("beq_t",  32'hFE208CE3, 12'h020, 12'h003, 12'h003, 6'b000001, 2'b01, 4'b0110, 12'hFFC, 12'h000, 1'b1, 12'h018, 1'b1, 12'h000);
    vecs[4] = mk("beq_nt", 32'hFE208CE3, 12'h020, 12'h003, 12'h004, 6'b000001, 2'b01, 4'b0110, 12'hFFC, 12'hFFF, 1'b0, 12'h018, 1'b0, 12'hFFF);
    vecs[5] = mk("ori",    32'h0F00E093, 12'h000, 12'h00F, 12'h000, 6'b100010, 2'b11, 4'b0001, 12'h0F0, 12'h0FF, 1'b0, 12'h1E0, 1'b0, 12'h0FF);
    vecs[6] = mk("and",    32'h0020F1B3, 12'h100, 12'hF0F, 12'h0FF, 6'b100000, 2'b10, 4'b0000, 12'h000, 12'h00F, 1'b0, 12'h100, 1'b0, 12'h00F);
    vecs[7] = mk("badop",  32'h0000007F, 12'h040, 12'h001, 12'h002, 6'b000000, 2'b00, 4'b0010, 12'h000, 12'h003, 1'b0, 12'h040, 1'b0, 12'h003);
    vecs[8] = mk("badf7",  32'h022081B3, 12'h000, 12'h005, 12'h007, 6'b000000, 2'b00, 4'b0010, 12'h000, 12'h00C, 1'b0, 12'h000, 1'b0, 12'h00C);
    vecs[9] = mk("addwrap",32'h002081B3, 12'hFFC, 12'hFFF, 12'h001, 6'b100000, 2'b10, 4'b0010, 12'h000, 12'h000, 1'b1, 12'hFFC, 1'b0, 12'h000);

    for (int unsigned i = 0; i < 32; i++) mem_init[i*12 +: 12] = 12'h200 + 12'(i);
    mem_init[11:0] = 12'h123;

    reset = 1'b0; instrucao = 32'h0; linha = '0; data1 = '0; data2 = '0;
    #1;
    chk("rst_word0", 32'(word(0)), 32'h123);
    chk("rst_word5", 32'(word(5)), 32'h205);
    chk("rst_word31", 32'(word(31)), 32'h21F);

    @(negedge clock); reset = 1'b1;
    #1;
    chk("post_rst_word5", 32'(word(5)), 32'h205);

    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clock);
      instrucao = vecs[i].instr; linha = vecs[i].pc; data1 = vecs[i].d1; data2 = vecs[i].d2;
      #1;
      chk({vecs[i].name, "_ctl"}, 32'({RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch}), 32'(vecs[i].ctl));
      chk({vecs[i].name, "_aluop"}, 32'(ALUOp), 32'(vecs[i].aluop));
      chk({vecs[i].name, "_aluctl"}, 32'(ALUcontrol), 32'(vecs[i].aluctl));
      chk({vecs[i].name, "_imm"}, 32'(ImmGen), 32'(vecs[i].imm));
      chk({vecs[i].name, "_res"}, 32'(ALUresult), 32'(vecs[i].res));
      chk({vecs[i].name, "_zero"}, 32'(zero), 32'(vecs[i].z));
      chk({vecs[i].name, "_sum"}, 32'(sum), 32'(vecs[i].tgt));
      chk({vecs[i].name, "_line"}, 32'(line), 32'(vecs[i].tkn));
      chk({vecs[i].name, "_wd"}, 32'(Writedata), 32'(vecs[i].wd));
    end

    // SW x2,8(x0): controls visible before the edge, memory updated after it.
    @(negedge clock);
    instrucao = 32'h00202423; linha = '0; data1 = 12'h000; data2 = 12'h0AB;
    #1;
    chk("sw_memwrite", 32'(MemWrite), 32'h1);
    chk("sw_regwrite", 32'(RegWrite), 32'h0);
    chk("sw_imm", 32'(ImmGen), 32'h008);
    chk("sw_res", 32'(ALUresult), 32'h008);
    chk("sw_word2_before", 32'(word(2)), 32'h202);
    @(posedge clock); #1;
    chk("sw_word2_after", 32'(word(2)), 32'h0AB);

    // LW x5,8(x0) reads the word stored at the previous edge.
    @(negedge clock);
    instrucao = 32'h00802283; data1 = 12'h000; data2 = 12'h000;
    #1;
    chk("lw_memread", 32'(MemRead), 32'h1);
    chk("lw_memtoreg", 32'(MemtoReg), 32'h1);
    chk("lw_wd", 32'(Writedata), 32'h0AB);

    // SW x2,20(x0) to word 5, then reset mid-cycle discards both stores.
    @(negedge clock);
    instrucao = 32'h00202A23; data1 = 12'h000; data2 = 12'h5A5;
    @(posedge clock); #1;
    chk("sw5_word5", 32'(word(5)), 32'h5A5);
    #2; reset = 1'b0;
    #1;
    chk("arst_word5", 32'(word(5)), 32'h205);
    chk("arst_word0", 32'(word(0)), 32'h123);
    chk("arst_word2", 32'(word(2)), 32'h202);
    chk("arst_memwrite", 32'(MemWrite), 32'h1);
    @(posedge clock); #1;
    chk("rst_edge_word5", 32'(word(5)), 32'h205);
    @(negedge clock); reset = 1'b1;
    #1;
    chk("rel_word5", 32'(word(5)), 32'h205);
    chk("rel_word2", 32'(word(2)), 32'h202);

    // Address 0x088 aliases to word 2 because bits [11:7] are ignored.
    instrucao = 32'h00802283; data1 = 12'h080;
    #1;
    chk("lw_wrap_res", 32'(ALUresult), 32'h088);
    chk("lw_wrap_wd", 32'(Writedata), 32'h202);

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/exec_ctrl_mem_unit.md
Name: exec_ctrl_mem_unit

Overview:
- Execute/memory slice of the 12-bit single-cycle RISC-V-subset datapath.
- Decodes the 32-bit instruction into control signals and a sign-extended immediate.
- Performs the ALU operation and resolves branches (target and taken flag).
- Holds the 32 x 12-bit data memory and drives register write-back data.
- Sits between the register file (supplies data1/data2) and the PC/fetch logic (consumes sum/line).

Parameters:
- DW, 12, datapath/data-word width
- MEM_WORDS, 32, data-memory depth in words

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset (0 = reset)
- instrucao  in  32  current instruction
- linha  in  12  current PC (byte address, step 4)
- data1  in  12  rs1 value
- data2  in  12  rs2 value
- mem_init  in  384  reset image of memory; word i = bits [12i+11:12i]
- RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch  out  1 each  control signals
- ALUOp  out  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
- ALUcontrol  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB
- ImmGen  out  12  signed immediate
- ALUresult  out  12  ALU output
- zero  out  1  ALUresult == 0
- sum  out  12  branch target
- line  out  1  branch taken
- Writedata  out  12  register write-back value
- Memoria_saida  out  384  full memory contents, same packing as mem_init

Behaviour:
- Decode is purely combinational; same-cycle outputs.
- Opcode decode:
  - 0110011 R-type: funct3 000 with funct7 0000000 = ADD; funct3 000 with funct7 0100000 = SUB; funct3 111 = AND; funct3 110 = OR. Sets RegWrite, ALUOp=10.
  - 0010011 I-type: funct3 000 ADDI, 111 ANDI, 110 ORI. Sets RegWrite, ALUSrc, ALUOp=11.
  - 0000011 LW (funct3 010): RegWrite, MemRead, MemtoReg, ALUSrc, ADD, ALUOp=00.
  - 0100011 SW (funct3 010): MemWrite, ALUSrc, ADD, ALUOp=00.
  - 1100011 BEQ (funct3 000): Branch, SUB, ALUOp=01.
- Any other opcode/funct combination: all 1-bit controls 0, ALUOp=00, ALUcontrol=ADD, ImmGen=0, line=0.
- ImmGen (12 bits):
  - I/LW: inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8]}, i.e. offset[12:1].
  - R: 0.
- ALU:
  - operand B = ALUSrc ? ImmGen : data2.
  - Two's-complement 12-bit arithmetic; overflow wraps, no flag.
- Branch:
  - sum = linha + (ImmGen << 1), truncated to 12 bits; always driven.
  - line = Branch & zero.
- Memory:
  - Word index = ALUresult[6:2]; bits [11:7] ignored, so addresses wrap.
  - Read is combinational.
  - Write on rising clock when MemWrite=1 and reset=1: mem[index] <= data2.
- Writedata = MemtoReg ? mem[index] : ALUresult.
- Reset:
  - While reset=0, every word is loaded from mem_init asynchronously and writes are blocked.
  - Memoria_saida reflects mem_init during reset.
  - Reset asserted mid-operation discards any prior writes.
- Store and load to the same index are in different cycles; a load reads the value written at the previous edge.

Decomposition:
- Shared package: opcode constants, ALUcontrol encodings, ALUOp encodings, DW, MEM_WORDS.
- One sub-module is natural: exec_ctrl_decoder (controls, ALUcontrol, ImmGen).
- ALU, branch logic and memory stay in the top.

Test Plan:
- ADD x3,x1,x2 = 0x002081B3, data1=5, data2=7 -> ALUresult=0x00C, RegWrite=1, ALUOp=10, Writedata=0x00C.
- SUB = 0x402081B3, data1=5, data2=7 -> ALUresult=0xFFE, zero=0.
- ADDI x1,x0,-1 = 0xFFF00093, data1=0 -> ImmGen=0xFFF, ALUSrc=1, ALUresult=0xFFF.
- SW x2,8(x0) = 0x00202423, data1=0, data2=0x0AB, one clock -> Memoria_saida word 2 = 0x0AB, MemWrite=1, RegWrite=0. Then LW x5,8(x0) = 0x00802283 -> Writedata=0x0AB.
- BEQ x1,x2,-8 = 0xFE208CE3, linha=0x020, data1=data2=3 -> ImmGen=0xFFC, sum=0x018, line=1. Same with data2=4 -> line=0, sum=0x018.
- mem_init word0=0x123 and a store to word 5, then reset=0 between edges -> word5 returns to its mem_init value and word0=0x123 immediately, without a clock edge. A clock edge with MemWrite=1 during reset leaves memory unchanged.
